// File: rtl/avst_frame_checker_pkg.sv
// Shared definitions for the Avalon-ST frame checker: error codes and FSM state encoding.
package avst_frame_checker_pkg;

    localparam int unsigned ERR_W = 3;

    localparam logic [ERR_W-1:0] ERR_NONE    = 3'd0;
    localparam logic [ERR_W-1:0] ERR_NO_SOP  = 3'd1;
    localparam logic [ERR_W-1:0] ERR_DUP_SOP = 3'd2;
    localparam logic [ERR_W-1:0] ERR_LEN     = 3'd3;
    localparam logic [ERR_W-1:0] ERR_EMPTY   = 3'd4;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_e;

endpackage

// File: rtl/avst_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module avst_frame_checker_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/avst_frame_checker.sv
// Avalon-ST sink terminating the sensor path: patterned backpressure, framing/length/empty
// checks, per-frame length and sum capture, and saturating good/error counters.
module avst_frame_checker
    import avst_frame_checker_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned WORDS_PER_FRAME = 163,
    parameter int unsigned LEN_W           = 9,
    parameter int unsigned CNT_W           = 16,
    parameter logic [7:0]  READY_PATTERN   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in_data,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    input  logic [1:0]        data_in_empty,
    input  logic              data_in_startofpacket,
    input  logic              data_in_endofpacket,
    output logic              frame_done,
    output logic              frame_ok,
    output logic [LEN_W-1:0]  last_len,
    output logic [31:0]       last_sum,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [2:0]        last_err
);

    localparam int unsigned       SUM_W   = 32;
    localparam logic [LEN_W-1:0]  LEN_MAX = '1;
    localparam logic [LEN_W-1:0]  WPF_L   = LEN_W'(WORDS_PER_FRAME);

    state_e           state_q, state_d;
    logic [2:0]       ptr_q;
    logic [LEN_W-1:0] len_q, len_d, len_inc_c, close_len_c, last_len_q;
    logic [SUM_W-1:0] sum_q, sum_d, data_ext_c, close_sum_c, last_sum_q;
    logic             ferr_q, ferr_d, lenerr_q, lenerr_d;
    logic             beat_c, empty_err_c, close_c, close_ok_c;
    logic [ERR_W-1:0] err_code_c, last_err_q;
    logic             frame_done_q, frame_ok_q;

    assign data_in_ready = READY_PATTERN[ptr_q];
    assign beat_c        = data_in_valid & data_in_ready;
    assign empty_err_c   = beat_c & (data_in_empty != 2'd0);
    assign data_ext_c    = SUM_W'(data_in_data);
    assign len_inc_c     = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame tracking; a close reports length/sum of the frame that just ended.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        ferr_d      = ferr_q;
        lenerr_d    = lenerr_q;
        close_c     = 1'b0;
        close_ok_c  = 1'b0;
        close_len_c = len_q;
        close_sum_c = sum_q;
        err_code_c  = ERR_NONE;
        if (beat_c) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (data_in_startofpacket) begin
                        state_d  = ST_IN_FRAME;
                        len_d    = LEN_W'(1);
                        sum_d    = data_ext_c;
                        ferr_d   = empty_err_c;
                        lenerr_d = 1'b0;
                        if (data_in_endofpacket) begin
                            state_d     = ST_IDLE;
                            close_c     = 1'b1;
                            close_len_c = LEN_W'(1);
                            close_sum_c = data_ext_c;
                            close_ok_c  = (WORDS_PER_FRAME == 1) && !empty_err_c;
                            if (WORDS_PER_FRAME != 1) begin
                                err_code_c = ERR_LEN;
                            end
                        end
                    end else begin
                        err_code_c = ERR_NO_SOP;
                    end
                end
                ST_IN_FRAME: begin
                    if (data_in_startofpacket) begin
                        // Old frame closes as bad; this beat opens the next one.
                        err_code_c = ERR_DUP_SOP;
                        close_c    = 1'b1;
                        len_d      = LEN_W'(1);
                        sum_d      = data_ext_c;
                        ferr_d     = empty_err_c;
                        lenerr_d   = 1'b0;
                        if (data_in_endofpacket) begin
                            state_d     = ST_IDLE;
                            close_len_c = LEN_W'(1);
                            close_sum_c = data_ext_c;
                        end
                    end else begin
                        len_d  = len_inc_c;
                        sum_d  = sum_q + data_ext_c;
                        ferr_d = ferr_q | empty_err_c;
                        if (data_in_endofpacket) begin
                            state_d     = ST_IDLE;
                            close_c     = 1'b1;
                            close_len_c = len_inc_c;
                            close_sum_c = sum_d;
                            close_ok_c  = !(ferr_d || lenerr_q || (len_inc_c != WPF_L));
                            if ((len_inc_c != WPF_L) && !lenerr_q) begin
                                err_code_c = ERR_LEN;
                            end
                        end else if ((len_q == WPF_L) && !lenerr_q) begin
                            err_code_c = ERR_LEN;
                            lenerr_d   = 1'b1;
                            ferr_d     = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (empty_err_c) begin
                err_code_c = ERR_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            len_q        <= '0;
            sum_q        <= '0;
            ferr_q       <= 1'b0;
            lenerr_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            last_len_q   <= '0;
            last_sum_q   <= '0;
            last_err_q   <= ERR_NONE;
        end else begin
            ptr_q        <= ptr_q + 3'd1;
            len_q        <= len_d;
            sum_q        <= sum_d;
            ferr_q       <= ferr_d;
            lenerr_q     <= lenerr_d;
            frame_done_q <= close_c;
            if (close_c) begin
                frame_ok_q <= close_ok_c;
            end
            if (clear) begin
                last_len_q <= '0;
                last_sum_q <= '0;
                last_err_q <= ERR_NONE;
            end else begin
                if (close_c) begin
                    last_len_q <= close_len_c;
                    last_sum_q <= close_sum_c;
                end
                if (err_code_c != ERR_NONE) begin
                    last_err_q <= err_code_c;
                end
            end
        end
    end

    avst_frame_checker_sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clear),
        .inc_i (close_c & close_ok_c),
        .cnt_o (frame_count)
    );

    avst_frame_checker_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clear),
        .inc_i (err_code_c != ERR_NONE),
        .cnt_o (err_count)
    );

    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign last_len   = last_len_q;
    assign last_sum   = last_sum_q;
    assign last_err   = last_err_q;

endmodule

// File: tb/tb_avst_frame_checker.sv
// Randomized bench for avst_frame_checker: two instances (full-width counters with ready=FF,
// narrow counters with ready=55) compared every cycle against a frame-level reference model.
module tb_avst_frame_checker;

    localparam logic [7:0] PAT_A = 8'hFF;
    localparam logic [7:0] PAT_B = 8'h55;
    localparam int         WPF   = 163;
    localparam int         LMAX  = 511;

    logic clk = 1'b0;
    logic rst;

    logic        a_clear, a_valid, a_sop, a_eop, a_ready, a_done, a_ok;
    logic [1:0]  a_emp;
    logic [31:0] a_data, a_sum;
    logic [8:0]  a_len;
    logic [15:0] a_fc, a_ec;
    logic [2:0]  a_lerr;

    logic        b_clear, b_valid, b_sop, b_eop, b_ready, b_done, b_ok;
    logic [1:0]  b_emp;
    logic [31:0] b_data, b_sum;
    logic [8:0]  b_len;
    logic [3:0]  b_fc, b_ec;
    logic [2:0]  b_lerr;

    always #5 clk = ~clk;

    avst_frame_checker #(.READY_PATTERN(PAT_A)) dut_a (
        .clk(clk), .rst(rst), .clear(a_clear),
        .data_in_data(a_data), .data_in_valid(a_valid), .data_in_ready(a_ready),
        .data_in_empty(a_emp), .data_in_startofpacket(a_sop), .data_in_endofpacket(a_eop),
        .frame_done(a_done), .frame_ok(a_ok), .last_len(a_len), .last_sum(a_sum),
        .frame_count(a_fc), .err_count(a_ec), .last_err(a_lerr)
    );

    avst_frame_checker #(.CNT_W(4), .READY_PATTERN(PAT_B)) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear),
        .data_in_data(b_data), .data_in_valid(b_valid), .data_in_ready(b_ready),
        .data_in_empty(b_emp), .data_in_startofpacket(b_sop), .data_in_endofpacket(b_eop),
        .frame_done(b_done), .frame_ok(b_ok), .last_len(b_len), .last_sum(b_sum),
        .frame_count(b_fc), .err_count(b_ec), .last_err(b_lerr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, one slot per instance.
    logic [7:0]  pat [2];
    int          cmax [2];
    logic [2:0]  m_ptr;
    bit          m_in [2], m_ferr [2], m_lflag [2];
    int          m_len [2];
    logic [31:0] m_sum [2];
    bit          e_done [2], e_ok [2];
    int          e_len [2], e_fc [2], e_ec [2], e_lerr [2];
    logic [31:0] e_sum [2];
    bit          rnd_clr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_in[k] = 0; m_ferr[k] = 0; m_lflag[k] = 0; m_len[k] = 0; m_sum[k] = '0;
        e_done[k] = 0; e_ok[k] = 0; e_len[k] = 0; e_sum[k] = '0;
        e_fc[k] = 0; e_ec[k] = 0; e_lerr[k] = 0;
    endtask

    task automatic model(input int k, input bit beat, input bit sop, input bit eop,
                         input logic [1:0] emp, input logic [31:0] dat, input bit clr);
        int code, c_len;
        bit close, c_ok, emp_err, bad_len;
        logic [31:0] c_sum;
        code = 0; c_len = 0; close = 0; c_ok = 0; c_sum = '0;
        emp_err = beat && (emp != 2'd0);
        if (beat) begin
            if (!m_in[k]) begin
                if (sop) begin
                    m_in[k] = 1; m_len[k] = 1; m_sum[k] = dat; m_ferr[k] = emp_err; m_lflag[k] = 0;
                    if (eop) begin
                        close = 1; c_len = 1; c_sum = dat; m_in[k] = 0;
                        bad_len = (WPF != 1);
                        if (bad_len) code = 3;
                        c_ok = !emp_err && !bad_len;
                    end
                end else begin
                    code = 1;
                end
            end else if (sop) begin
                code = 2; close = 1; c_len = m_len[k]; c_sum = m_sum[k]; c_ok = 0;
                m_len[k] = 1; m_sum[k] = dat; m_ferr[k] = emp_err; m_lflag[k] = 0;
                if (eop) begin
                    c_len = 1; c_sum = dat; m_in[k] = 0;
                end
            end else begin
                m_len[k] = m_len[k] + 1;
                m_sum[k] = m_sum[k] + dat;
                if (emp_err) m_ferr[k] = 1;
                if (eop) begin
                    close = 1; c_len = m_len[k]; c_sum = m_sum[k]; m_in[k] = 0;
                    bad_len = (m_len[k] != WPF);
                    if (bad_len && !m_lflag[k]) code = 3;
                    c_ok = !m_ferr[k] && !bad_len;
                end else if ((m_len[k] - 1 == WPF) && !m_lflag[k]) begin
                    code = 3; m_lflag[k] = 1; m_ferr[k] = 1;
                end
            end
            if (emp_err) code = 4;
        end
        e_done[k] = close;
        if (close) e_ok[k] = c_ok;
        if (clr) begin
            e_len[k] = 0; e_sum[k] = '0; e_lerr[k] = 0; e_fc[k] = 0; e_ec[k] = 0;
        end else begin
            if (close) begin
                e_len[k] = (c_len > LMAX) ? LMAX : c_len;
                e_sum[k] = c_sum;
            end
            if (code != 0) begin
                e_lerr[k] = code;
                if (e_ec[k] < cmax[k]) e_ec[k]++;
            end
            if (close && c_ok && (e_fc[k] < cmax[k])) e_fc[k]++;
        end
    endtask

    task automatic compare(input int k);
        logic        d_done, d_ok;
        logic [31:0] d_len, d_sum, d_fc, d_ec, d_lerr;
        if (k == 0) begin
            d_done = a_done; d_ok = a_ok; d_len = 32'(a_len); d_sum = a_sum;
            d_fc = 32'(a_fc); d_ec = 32'(a_ec); d_lerr = 32'(a_lerr);
        end else begin
            d_done = b_done; d_ok = b_ok; d_len = 32'(b_len); d_sum = b_sum;
            d_fc = 32'(b_fc); d_ec = 32'(b_ec); d_lerr = 32'(b_lerr);
        end
        chk($sformatf("frame_done[%0d]", k), 32'(d_done), 32'(e_done[k]));
        if (e_done[k]) chk($sformatf("frame_ok[%0d]", k), 32'(d_ok), 32'(e_ok[k]));
        chk($sformatf("last_len[%0d]", k), d_len, 32'(e_len[k]));
        chk($sformatf("last_sum[%0d]", k), d_sum, e_sum[k]);
        chk($sformatf("frame_count[%0d]", k), d_fc, 32'(e_fc[k]));
        chk($sformatf("err_count[%0d]", k), d_ec, 32'(e_ec[k]));
        chk($sformatf("last_err[%0d]", k), d_lerr, 32'(e_lerr[k]));
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_clear = 0; b_valid = 0; b_clear = 0;
    endtask

    // One clock: drive instance d, advance, update both models and compare both instances.
    task automatic step(input int d, input bit v, input bit sop, input bit eop,
                        input logic [1:0] emp, input logic [31:0] dat, input bit clr,
                        output bit acc);
        bit rdy_exp;
        rdy_exp = pat[d][m_ptr];
        if (d == 0) begin
            a_valid = v; a_sop = sop; a_eop = eop; a_emp = emp; a_data = dat; a_clear = clr;
        end else begin
            b_valid = v; b_sop = sop; b_eop = eop; b_emp = emp; b_data = dat; b_clear = clr;
        end
        chk("ready[0]", 32'(a_ready), 32'(pat[0][m_ptr]));
        chk("ready[1]", 32'(b_ready), 32'(pat[1][m_ptr]));
        acc = v && rdy_exp;
        @(posedge clk);
        #1;
        m_ptr = m_ptr + 3'd1;
        for (int k = 0; k < 2; k++) begin
            if (k == d) model(k, acc, sop, eop, emp, dat, clr);
            else        model(k, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
            compare(k);
        end
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_ptr = '0;
        model_reset(0);
        model_reset(1);
        compare(0);
        compare(1);
        rst = 1'b0;
    endtask

    task automatic send_word(input int d, input bit sop, input bit eop,
                             input logic [1:0] emp, input logic [31:0] dat);
        bit acc;
        int tries;
        if ($urandom_range(0, 3) == 0) step(d, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, acc);
        acc = 0;
        tries = 0;
        while (!acc && tries < 16) begin
            step(d, 1'b1, sop, eop, emp, dat, rnd_clr && ($urandom_range(0, 63) == 0), acc);
            tries++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int d, input int first, input int n, input int sop_at,
                              input int emp_at, input bit seq, input bit eop_en);
        logic [31:0] dat;
        logic [1:0]  emp;
        for (int i = first; i <= n; i++) begin
            dat = seq ? 32'(i) : $urandom;
            emp = (i == emp_at) ? (seq ? 2'd2 : 2'($urandom_range(1, 3))) : 2'd0;
            send_word(d, (i == 1) || (i == sop_at), eop_en && (i == n), emp, dat);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        pat[0] = PAT_A; pat[1] = PAT_B;
        cmax[0] = 65535; cmax[1] = 15;
        a_sop = 0; a_eop = 0; a_emp = 0; a_data = 0;
        b_sop = 0; b_eop = 0; b_emp = 0; b_data = 0;
        idle_inputs();
        rst = 1'b1;
        do_reset();
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_fc", 32'(a_fc), 32'd0);

        // Clean 163-beat frame, data 1..163.
        send_frame(0, 1, WPF, 0, 0, 1'b1, 1'b1);
        chk("t1_done", 32'(a_done), 32'd1);
        chk("t1_ok", 32'(a_ok), 32'd1);
        chk("t1_len", 32'(a_len), 32'd163);
        chk("t1_sum", a_sum, 32'd13366);
        chk("t1_fc", 32'(a_fc), 32'd1);

        // Short frame.
        step(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, acc);
        send_frame(0, 1, WPF - 1, 0, 0, 1'b1, 1'b1);
        chk("t3_ok", 32'(a_ok), 32'd0);
        chk("t3_lerr", 32'(a_lerr), 32'd3);
        chk("t3_ec", 32'(a_ec), 32'd1);
        chk("t3_fc", 32'(a_fc), 32'd0);

        // SOP on beat 50 restarts a full frame.
        step(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, acc);
        send_frame(0, 1, 49, 0, 0, 1'b1, 1'b0);
        send_word(0, 1'b1, 1'b0, 2'd0, 32'd1);
        chk("t4a_done", 32'(a_done), 32'd1);
        chk("t4a_ok", 32'(a_ok), 32'd0);
        chk("t4a_len", 32'(a_len), 32'd49);
        chk("t4a_sum", a_sum, 32'd1225);
        chk("t4a_lerr", 32'(a_lerr), 32'd2);
        send_frame(0, 2, WPF, 0, 0, 1'b1, 1'b1);
        chk("t4b_ok", 32'(a_ok), 32'd1);
        chk("t4b_len", 32'(a_len), 32'd163);
        chk("t4b_fc", 32'(a_fc), 32'd1);

        // Stray beat in IDLE, then empty!=0 inside a frame.
        step(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, acc);
        send_word(0, 1'b0, 1'b0, 2'd0, 32'd5);
        chk("t5_lerr1", 32'(a_lerr), 32'd1);
        send_frame(0, 1, WPF, 0, 10, 1'b1, 1'b1);
        chk("t5_ok", 32'(a_ok), 32'd0);
        chk("t5_ec", 32'(a_ec), 32'd2);
        chk("t5_lerr", 32'(a_lerr), 32'd4);
        chk("t5_fc", 32'(a_fc), 32'd0);

        // Randomized frames with random clears.
        rnd_clr = 1'b1;
        for (int f = 0; f < 25; f++) begin
            int n, sel, sop_at, emp_at;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       n = WPF;
                1:       n = WPF - 1;
                2:       n = WPF + 1;
                3:       n = int'($urandom_range(1, 600));
                4:       n = WPF;
                default: n = int'($urandom_range(160, 166));
            endcase
            sop_at = (n > 3 && $urandom_range(0, 5) == 0) ? int'($urandom_range(2, n - 1)) : 0;
            emp_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, n)) : 0;
            if ($urandom_range(0, 7) == 0) send_word(0, 1'b0, 1'b0, 2'd0, $urandom);
            send_frame(0, 1, n, sop_at, emp_at, 1'b0, 1'b1);
        end
        rnd_clr = 1'b0;

        // Instance with 0x55 backpressure.
        send_frame(1, 1, WPF, 0, 0, 1'b1, 1'b1);
        chk("t2_done", 32'(b_done), 32'd1);
        chk("t2_ok", 32'(b_ok), 32'd1);
        chk("t2_len", 32'(b_len), 32'd163);
        chk("t2_sum", b_sum, 32'd13366);
        chk("t2_fc", 32'(b_fc), 32'd1);

        // Counter saturation on the 4-bit instance.
        for (int f = 0; f < 15; f++) send_frame(1, 1, WPF, 0, 0, 1'b0, 1'b1);
        chk("t6_fc_sat", 32'(b_fc), 32'hF);
        step(1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, acc);
        chk("t6_fc_clr", 32'(b_fc), 32'd0);
        for (int i = 0; i < 17; i++) send_word(1, 1'b0, 1'b0, 2'd0, $urandom);
        chk("t6_ec_sat", 32'(b_ec), 32'hF);

        // Reset in the middle of a frame, then a proper frame.
        send_frame(1, 1, 80, 0, 0, 1'b0, 1'b0);
        do_reset();
        chk("t6_rst_ec", 32'(b_ec), 32'd0);
        chk("t6_rst_lerr", 32'(b_lerr), 32'd0);
        send_frame(1, 1, WPF, 0, 0, 1'b0, 1'b1);
        chk("t6_post_ok", 32'(b_ok), 32'd1);
        chk("t6_post_fc", 32'(b_fc), 32'd1);
        chk("t6_post_len", 32'(b_len), 32'd163);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
